// File: rtl/prog_loader_pkg.sv
// Shared sizes and state encoding for the program loader and its RAM port.
package prog_loader_pkg;

  localparam int unsigned MemAddrW = 5;
  localparam int unsigned MemDataW = 8;
  localparam int unsigned MemDepth = 2 ** MemAddrW;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StVerify = 3'd2,
    StDone   = 3'd3,
    StError  = 3'd4
  } ldr_state_e;

endpackage

// File: rtl/prog_loader_byte_checksum.sv
// Running mod-2^DATA_W sum of accepted bytes; clr wins over en.
module prog_loader_byte_checksum #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q + data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a program image into the program RAM, reads it back and compares checksums.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = MemAddrW,
  parameter int unsigned DATA_W = MemDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  localparam int unsigned LenW = ADDR_W + 1;

  ldr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LenW-1:0]   len_q, len_d;
  logic              sum_clr, wsum_en, rsum_en;
  logic [DATA_W-1:0] wsum, rsum, rsum_final;
  logic              last;

  assign last       = ({1'b0, addr_q} == (len_q - LenW'(1)));
  assign rsum_final = rsum + ram_read_data;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    sum_clr        = 1'b0;
    wsum_en        = 1'b0;
    rsum_en        = 1'b0;
    in_ready       = 1'b0;
    ram_read_en    = 1'b0;
    ram_write_en   = 1'b0;
    ram_address    = '0;
    ram_write_data = '0;
    busy           = 1'b0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          // Oversized requests are clamped so addr never has to wrap.
          len_d   = (32'(len) > MemDepth) ? LenW'(MemDepth) : len;
          addr_d  = '0;
          sum_clr = 1'b1;
          state_d = (len == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        busy           = 1'b1;
        in_ready       = 1'b1;
        ram_write_en   = in_valid;
        ram_address    = addr_q;
        ram_write_data = in_data;
        if (in_valid) begin
          wsum_en = 1'b1;
          if (last) begin
            addr_d  = '0;
            state_d = StVerify;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      StVerify: begin
        busy        = 1'b1;
        ram_read_en = 1'b1;
        ram_address = addr_q;
        rsum_en     = 1'b1;
        if (last) begin
          state_d = (rsum_final == wsum) ? StDone : StError;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
    end
  end

  prog_loader_byte_checksum #(
    .DATA_W (DATA_W)
  ) u_wsum (
    .clk  (clk),
    .rst  (rst),
    .clr  (sum_clr),
    .en   (wsum_en),
    .data (in_data),
    .sum  (wsum)
  );

  prog_loader_byte_checksum #(
    .DATA_W (DATA_W)
  ) u_rsum (
    .clk  (clk),
    .rst  (rst),
    .clr  (sum_clr),
    .en   (rsum_en),
    .data (ram_read_data),
    .sum  (rsum)
  );

  assign cpu_halt = busy;
  assign done     = (state_q == StDone);
  assign error    = (state_q == StError);
  assign checksum = wsum;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: behavioural RAM, write scoreboard and read-address tracking.
module tb_prog_loader;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready;
  logic [AW:0]   len;
  logic [DW-1:0] in_data, ram_write_data, ram_read_data, checksum;
  logic          ram_read_en, ram_write_en, cpu_halt, busy, done, error;
  logic [AW-1:0] ram_address;

  logic [DW-1:0] ram [32];
  logic          flip_en = 1'b0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t           wr_q[$];
  wr_t           mon_e;
  logic [DW-1:0] img [32];

  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_reads = 0;
  logic [AW-1:0] exp_raddr = '0;
  int            cyc;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .len            (len),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .ram_read_en    (ram_read_en),
    .ram_write_en   (ram_write_en),
    .ram_address    (ram_address),
    .ram_write_data (ram_write_data),
    .ram_read_data  (ram_read_data),
    .cpu_halt       (cpu_halt),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .checksum       (checksum)
  );

  // Combinational-read RAM; optional single-bit corruption at address 2.
  assign ram_read_data = ram[ram_address] ^
                         {7'd0, flip_en && ram_read_en && (ram_address == 5'd2)};
  always @(posedge clk) if (ram_write_en) ram[ram_address] <= ram_write_data;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_write_en) begin
        check_val("rw_excl", {31'd0, ram_read_en}, 0);
        check_val("wr_expected", {31'd0, wr_q.size() != 0}, 1);
        if (wr_q.size() != 0) begin
          mon_e = wr_q.pop_front();
          check_val("wr_addr", {27'd0, ram_address}, {27'd0, mon_e.a});
          check_val("wr_data", {24'd0, ram_write_data}, {24'd0, mon_e.d});
        end
      end
      if (ram_read_en) begin
        n_reads++;
        check_val("rd_addr", {27'd0, ram_address}, {27'd0, exp_raddr});
        exp_raddr = exp_raddr + 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int l);
    start     = 1'b1;
    len       = l[AW:0];
    exp_raddr = '0;
    n_reads   = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap, input logic [AW-1:0] a);
    in_valid = 1'b1;
    in_data  = b;
    img[a]   = b;
    wr_q.push_back({a, b});
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_end(output int c);
    c = 0;
    while (!(done || error) && c < 200) begin
      tick();
      c++;
    end
    check_val("ended", {31'd0, done | error}, 1);
  endtask

  task automatic check_image(input int l);
    for (int i = 0; i < l; i++) check_val("ram_img", {24'd0, ram[i]}, {24'd0, img[i]});
    check_val("wr_q_empty", wr_q.size(), 0);
  endtask

  task automatic check_quiet(input string tag);
    check_val(tag, {22'd0, in_ready, busy, cpu_halt, done, error, ram_read_en, ram_write_en,
                    ram_address}, 0);
    check_val({tag, "_cks"}, {24'd0, checksum}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    check_quiet("reset");

    // 1: back-to-back image, done 9 cycles after start.
    launch(4);
    check_val("load_flags", {29'd0, busy, cpu_halt, in_ready}, 3'b111);
    send(8'h11, 0, 0); send(8'h22, 0, 1); send(8'h33, 0, 2); send(8'h44, 0, 3);
    wait_end(cyc);
    check_val("t1_latency", cyc, 4);
    check_val("t1_flags", {30'd0, done, error}, 2'b10);
    check_val("t1_cks", {24'd0, checksum}, 32'hAA);
    check_val("t1_reads", n_reads, 4);
    check_image(4);

    // 2: same image with two idle cycles between bytes.
    launch(4);
    send(8'h11, 2, 0); send(8'h22, 2, 1); send(8'h33, 2, 2); send(8'h44, 2, 3);
    wait_end(cyc);
    check_val("t2_flags", {30'd0, done, error}, 2'b10);
    check_val("t2_cks", {24'd0, checksum}, 32'hAA);
    check_image(4);

    // 3: full-depth image.
    launch(32);
    for (int i = 0; i < 32; i++) send(i[7:0], 0, i[AW-1:0]);
    wait_end(cyc);
    check_val("t3_latency", cyc, 32);
    check_val("t3_flags", {30'd0, done, error}, 2'b10);
    check_val("t3_cks", {24'd0, checksum}, 32'hF0);
    check_val("t3_reads", n_reads, 32);
    check_image(32);

    // 4: corrupted read-back must flag an error.
    flip_en = 1'b1;
    launch(4);
    send(8'h11, 0, 0); send(8'h22, 0, 1); send(8'h33, 0, 2); send(8'h44, 0, 3);
    wait_end(cyc);
    flip_en = 1'b0;
    check_val("t4_flags", {28'd0, done, error, busy, cpu_halt}, 4'b0100);

    // 5: reset mid-load, then a one-byte image.
    launch(4);
    send(8'h0F, 0, 0); send(8'h24, 0, 1);
    rst = 1'b1;
    tick();
    check_quiet("t5_reset");
    rst = 1'b0;
    launch(1);
    send(8'h5A, 0, 0);
    wait_end(cyc);
    check_val("t5_latency", cyc, 1);
    check_val("t5_flags", {30'd0, done, error}, 2'b10);
    check_val("t5_cks", {24'd0, checksum}, 32'h5A);
    check_image(1);

    // 6: zero-length load, then a start pulse during LOAD that must be ignored.
    launch(0);
    check_val("t6_done", {31'd0, done}, 1);
    check_val("t6_idle", {29'd0, busy, ram_read_en, ram_write_en}, 0);
    tick();
    check_val("t6_reads", n_reads, 0);
    launch(2);
    send(8'h10, 0, 0);
    start = 1'b1;
    len   = 6'd5;
    send(8'h20, 0, 1);
    start = 1'b0;
    wait_end(cyc);
    check_val("t6_latency", cyc, 2);
    check_val("t6_flags", {30'd0, done, error}, 2'b10);
    check_val("t6_cks", {24'd0, checksum}, 32'h30);
    check_val("t6_reads2", n_reads, 2);
    check_image(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
